// File: rtl/pattern_store_ddr.sv
// pattern_store_ddr: packs a host pixel stream into a header word plus 256-bit body words and writes them to DDR3 via EMIF Avalon-MM; ports: clk/rst, start+cfg_*, pix_valid/pix_data/pix_ready, busy/done, ddr_emif_* write port
module pattern_store_ddr #(
  parameter int PIX_PER_WORD = 8,
  parameter int ADDR_W = 22
) (
  input  logic              ddr_emif_clk,
  input  logic              ddr_emif_rst,
  input  logic              start,
  input  logic [11:0]       cfg_h_pix,
  input  logic [11:0]       cfg_v_pix,
  input  logic [31:0]       cfg_pat_num,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic              pix_valid,
  input  logic [23:0]       pix_data,
  output logic              pix_ready,
  output logic              busy,
  output logic              done,
  input  logic              ddr_emif_ready,
  output logic              ddr_emif_write,
  output logic              ddr_emif_read,
  output logic [ADDR_W-1:0] ddr_emif_addr,
  output logic [255:0]      ddr_emif_write_data,
  output logic [31:0]       ddr_emif_byte_enable,
  output logic [4:0]        ddr_emif_burst_count
);
  typedef enum logic [2:0] {S_IDLE, S_HEAD, S_PACK, S_WRITE, S_DONE} state_t;
  state_t r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [255:0] r_data;
  logic [2:0] r_slot;
  logic [31:0] r_remain;
  logic [23:0] w_prod;
  logic [31:0] w_total, w_words, w_fill;
  logic [ADDR_W-1:0] w_start, w_end;
  logic [255:0] w_header;
  logic w_wr_acc, w_pix_acc, w_last;
  assign w_prod = cfg_h_pix * cfg_v_pix;
  assign w_total = {8'd0, w_prod};
  assign w_words = (w_total + 32'd7) >> 3;
  assign w_fill = (w_words << 3) - w_total;
  assign w_start = cfg_base_addr + ADDR_W'(1);
  assign w_end = cfg_base_addr + w_words[ADDR_W-1:0];
  assign w_header = {20'd0, cfg_h_pix, 20'd0, cfg_v_pix, w_total, cfg_pat_num, w_fill,
                     {(32-ADDR_W){1'b0}}, w_start, {(32-ADDR_W){1'b0}}, w_end, 32'd0};
  assign w_wr_acc = ddr_emif_write & ddr_emif_ready;
  assign w_pix_acc = pix_valid & pix_ready;
  // a word closes on its last slot or on the final pixel of the image
  assign w_last = (r_slot == 3'(PIX_PER_WORD-1)) || (r_remain == 32'd1);
  assign pix_ready = r_state == S_PACK;
  assign busy = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done = r_state == S_DONE;
  assign ddr_emif_write = (r_state == S_HEAD) || (r_state == S_WRITE);
  assign ddr_emif_read = 1'b0;
  assign ddr_emif_addr = r_addr;
  assign ddr_emif_write_data = r_data;
  assign ddr_emif_byte_enable = '1;
  assign ddr_emif_burst_count = 5'd1;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: w_next = start ? S_HEAD : S_IDLE;
      S_HEAD, S_WRITE: w_next = w_wr_acc ? ((r_remain != 32'd0) ? S_PACK : S_DONE) : r_state;
      S_PACK: w_next = (w_pix_acc && w_last) ? S_WRITE : S_PACK;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge ddr_emif_clk) begin
    if (ddr_emif_rst) begin
      r_state <= S_IDLE;
      r_addr <= '0;
      r_data <= '0;
      r_slot <= '0;
      r_remain <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (start) begin
          r_addr <= cfg_base_addr;
          r_data <= w_header;
          r_remain <= w_total;
          r_slot <= '0;
        end
        S_HEAD, S_WRITE: if (w_wr_acc) begin
          r_addr <= r_addr + ADDR_W'(1);
          r_data <= '0;
          r_slot <= '0;
        end
        S_PACK: if (w_pix_acc) begin
          r_data[{r_slot, 5'd0} +: 32] <= {8'd0, pix_data};
          r_slot <= r_slot + 3'd1;
          r_remain <= r_remain - 32'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pattern_store_ddr.sv
// tb_pattern_store_ddr: randomized scoreboard bench for pattern_store_ddr
module tb_pattern_store_ddr;
  logic clk = 0, rst = 1, start = 0;
  logic [11:0] cfg_h_pix = 0, cfg_v_pix = 0;
  logic [31:0] cfg_pat_num = 0;
  logic [21:0] cfg_base_addr = 0;
  logic pix_valid = 0;
  logic [23:0] pix_data = 0;
  logic pix_ready, busy, done;
  logic ddr_emif_ready = 1;
  logic ddr_emif_write, ddr_emif_read;
  logic [21:0] ddr_emif_addr;
  logic [255:0] ddr_emif_write_data;
  logic [31:0] ddr_emif_byte_enable;
  logic [4:0] ddr_emif_burst_count;
  typedef struct {logic [21:0] a; logic [255:0] d;} wr_t;
  wr_t exp_q[$];
  logic [23:0] pix_mem[$];
  int checks = 0, failures = 0, pix_cnt = 0, done_cnt = 0, ready_mode = 0, stall = 0;
  bit hdr_stall = 0, pw = 0;
  pattern_store_ddr dut (
    .ddr_emif_clk(clk), .ddr_emif_rst(rst), .start(start),
    .cfg_h_pix(cfg_h_pix), .cfg_v_pix(cfg_v_pix), .cfg_pat_num(cfg_pat_num),
    .cfg_base_addr(cfg_base_addr), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_ready(pix_ready), .busy(busy), .done(done), .ddr_emif_ready(ddr_emif_ready),
    .ddr_emif_write(ddr_emif_write), .ddr_emif_read(ddr_emif_read),
    .ddr_emif_addr(ddr_emif_addr), .ddr_emif_write_data(ddr_emif_write_data),
    .ddr_emif_byte_enable(ddr_emif_byte_enable), .ddr_emif_burst_count(ddr_emif_burst_count)
  );
  always #5 clk = ~clk;
  task automatic chk(string name, logic [255:0] act, logic [255:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask
  // EMIF backpressure: always ready, random, or scripted stalls (5 on header, 3 on each body word)
  always @(posedge clk) begin
    #1;
    if (ready_mode == 0) ddr_emif_ready = 1;
    else if (ready_mode == 1) ddr_emif_ready = ($urandom % 3) != 0;
    else begin
      if (ddr_emif_write && !pw) begin
        stall = hdr_stall ? 5 : 3;
        hdr_stall = 0;
      end
      ddr_emif_ready = (stall == 0);
      if (stall > 0) stall--;
    end
    pw = ddr_emif_write;
  end
  // monitor: pops the scoreboard on every accepted write
  always @(negedge clk) begin
    if (!rst) begin
      if (ddr_emif_write && ddr_emif_ready) begin
        chk("byte_enable", ddr_emif_byte_enable, 32'hFFFFFFFF);
        if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", ddr_emif_addr, e.a);
          chk("wr_data", ddr_emif_write_data, e.d);
        end
      end
      if (pix_valid && pix_ready) pix_cnt++;
      if (done) begin
        done_cnt++;
        chk("busy_in_done", busy, 0);
      end
    end
  end
  task automatic expect_job(int h, int v, logic [31:0] pat, logic [21:0] base);
    int total, words, fill;
    logic [255:0] d;
    total = h * v;
    words = (total + 7) / 8;
    fill = words * 8 - total;
    d = {32'(h), 32'(v), 32'(total), pat, 32'(fill), 32'(22'(base + 1)), 32'(22'(base + words)), 32'd0};
    exp_q.push_back('{base, d});
    for (int w = 0; w < words; w++) begin
      d = '0;
      for (int k = 0; k < 8; k++)
        if (w * 8 + k < total) d[32*k +: 32] = {8'd0, pix_mem[w*8+k]};
      exp_q.push_back('{22'(base + 1 + w), d});
    end
  endtask
  task automatic issue_start(int h, int v, logic [31:0] pat, logic [21:0] base, bit seq);
    pix_mem.delete();
    for (int i = 0; i < h * v; i++) pix_mem.push_back(seq ? 24'(i + 1) : 24'($urandom));
    hdr_stall = 1;
    expect_job(h, v, pat, base);
    pix_cnt = 0;
    done_cnt = 0;
    cfg_h_pix = 12'(h);
    cfg_v_pix = 12'(v);
    cfg_pat_num = pat;
    cfg_base_addr = base;
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
  endtask
  task automatic run_job(int h, int v, logic [31:0] pat, logic [21:0] base, int rmode, bit poke, bit seq);
    int idx = 0, cyc = 0, n = h * v;
    bit fin = 0;
    ready_mode = rmode;
    issue_start(h, v, pat, base, seq);
    while (!fin && cyc < 5000) begin
      pix_valid = (idx < n) ? (($urandom % 4) != 0) : ($urandom % 2 == 1);
      pix_data = (idx < n) ? pix_mem[idx] : 24'($urandom);
      start = poke && (cyc == 4);
      if (start) cfg_base_addr = 22'h155;
      @(negedge clk);
      if (pix_valid && pix_ready && idx < n) idx++;
      if (done) fin = 1;
      @(posedge clk);
      #1;
      start = 0;
      cyc++;
    end
    pix_valid = 0;
    chk("job_finished", fin, 1);
    chk("all_writes_issued", exp_q.size(), 0);
    chk("pixels_accepted", pix_cnt, n);
    chk("done_pulses", done_cnt, 1);
    exp_q.delete();
  endtask
  task automatic check_reset(string tag);
    chk({tag, "_pix_ready"}, pix_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_write"}, ddr_emif_write, 0);
    chk({tag, "_read"}, ddr_emif_read, 0);
    chk({tag, "_addr"}, ddr_emif_addr, 0);
    chk({tag, "_data"}, ddr_emif_write_data, 0);
    chk({tag, "_be"}, ddr_emif_byte_enable, 32'hFFFFFFFF);
    chk({tag, "_burst"}, ddr_emif_burst_count, 1);
  endtask
  initial begin
    int idx, cyc;
    repeat (3) @(posedge clk);
    #1;
    check_reset("por");
    rst = 0;
    run_job(4, 2, 5, 22'h100, 0, 0, 1);
    run_job(3, 3, 7, 22'h000, 0, 0, 0);
    run_job(4, 2, 5, 22'h100, 2, 0, 1);
    run_job(0, 480, 1, 22'h200, 1, 0, 0);
    run_job(8, 1, 3, 22'h3FFFFF, 0, 1, 0);
    ready_mode = 0;
    issue_start(4, 2, 9, 22'h040, 0);
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    idx = 0;
    cyc = 0;
    while (idx < 3 && cyc < 100) begin
      pix_valid = 1;
      pix_data = pix_mem[idx];
      @(negedge clk);
      if (pix_valid && pix_ready) idx++;
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("mid_pixels", idx, 3);
    rst = 1;
    pix_valid = 0;
    @(posedge clk);
    #1;
    check_reset("mid");
    rst = 0;
    chk("mid_header_written", exp_q.size(), 0);
    exp_q.delete();
    run_job(4, 2, 9, 22'h040, 1, 0, 0);
    for (int i = 0; i < 6; i++)
      run_job($urandom_range(1, 12), $urandom_range(1, 12), $urandom, 22'($urandom), 1, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
